// File: rtl/ie_muldiv.sv
// ie_muldiv: execute stage with forwarding, ALU, branch resolve and an optional iterative RV32M unit.
// Define IE_MULDIV_M_EXT_EN to build the multiply/divide FSM; without it isM is ignored and stall is 0.

module ie_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            inValid,
    input  logic            flush,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pcP,
    input  logic [XLEN-1:0] aluOutMem,
    input  logic [XLEN-1:0] wbData,
    input  logic [1:0]      fwdA,
    input  logic [1:0]      fwdB,
    input  logic            aluS1,
    input  logic            aluS2,
    input  logic [3:0]      aluOp,
    input  logic            isM,
    input  logic [2:0]      mOp,
    input  logic [2:0]      bCtrl,
    input  logic            doBranch,
    input  logic            doJump,
    output logic            stall,
    output logic            outValid,
    output logic [XLEN-1:0] result,
    output logic            bSel
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] op_a, op_b, src1, src2, alu_res, result_q;
    logic [SW-1:0]   shamt;
    logic            cond, take, accept, outValid_q, bSel_q;

    always_comb begin
        case (fwdA)
            2'b01:   op_a = aluOutMem;
            2'b10:   op_a = wbData;
            default: op_a = r1;
        endcase
        case (fwdB)
            2'b01:   op_b = aluOutMem;
            2'b10:   op_b = wbData;
            default: op_b = r2;
        endcase
    end

    assign src1  = aluS1 ? op_a : pcP;
    assign src2  = aluS2 ? imm : op_b;
    assign shamt = src2[SW-1:0];

    // ALU encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass src2
    always_comb begin
        alu_res = '0;
        case (aluOp)
            4'd0:    alu_res = src1 + src2;
            4'd1:    alu_res = src1 - src2;
            4'd2:    alu_res = src1 << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
            4'd5:    alu_res = src1 ^ src2;
            4'd6:    alu_res = src1 >> shamt;
            4'd7:    alu_res = $unsigned($signed(src1) >>> shamt);
            4'd8:    alu_res = src1 | src2;
            4'd9:    alu_res = src1 & src2;
            4'd10:   alu_res = src2;
            default: alu_res = '0;
        endcase
    end

    // Branch conditions follow RV32I funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU).
    always_comb begin
        cond = 1'b0;
        case (bCtrl)
            3'b000:  cond = (op_a == op_b);
            3'b001:  cond = (op_a != op_b);
            3'b100:  cond = ($signed(op_a) < $signed(op_b));
            3'b101:  cond = ($signed(op_a) >= $signed(op_b));
            3'b110:  cond = (op_a < op_b);
            3'b111:  cond = (op_a >= op_b);
            default: cond = 1'b0;
        endcase
    end

    assign take   = doJump | (doBranch & cond);
    assign accept = inValid & ~stall & ~flush;

`ifdef IE_MULDIV_M_EXT_EN
    // state | meaning
    // IDLE  | accepting ops; ALU ops complete from here in one cycle
    // MUL   | shift-add, one multiplier bit per cycle
    // DIV   | restoring divide on magnitudes, one quotient bit per cycle
    // DONE  | signed result presented with outValid for one cycle
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q;
    logic [SW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, mcand_q, acc_next, prod;
    logic [XLEN-1:0]   mplier_q, a_mag, b_mag, quo, rem, m_res, special_res;
    logic [XLEN:0]     div_part, div_trial;
    logic [2:0]        mop_q;
    logic              neg_q, rneg_q, a_sgn, b_sgn, div_zero, div_ovf;

    assign a_sgn = op_a[XLEN-1] & (mOp == 3'b001 || mOp == 3'b010 || mOp == 3'b100 || mOp == 3'b110);
    assign b_sgn = op_b[XLEN-1] & (mOp == 3'b001 || mOp == 3'b100 || mOp == 3'b110);
    assign a_mag = a_sgn ? -op_a : op_a;
    assign b_mag = b_sgn ? -op_b : op_b;

    assign div_zero    = (op_b == '0);
    assign div_ovf     = ~mOp[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    assign special_res = div_zero ? (mOp[1] ? op_a : '1) : (mOp[1] ? '0 : op_a);

    // acc_q holds the product for MUL and {remainder, dividend/quotient} for DIV.
    assign div_part  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_trial = div_part - {1'b0, mcand_q[XLEN-1:0]};

    always_comb begin
        acc_next = acc_q;
        if (state_q == MUL) begin
            if (mplier_q[0]) acc_next = acc_q + mcand_q;
        end else if (!div_trial[XLEN]) begin
            acc_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    assign prod = neg_q ? -acc_next : acc_next;
    assign quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign rem  = rneg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

    always_comb begin
        if (!mop_q[2]) m_res = (mop_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else           m_res = mop_q[1] ? rem : quo;
    end

    assign stall = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            mop_q      <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            outValid_q <= 1'b0;
            bSel_q     <= 1'b0;
            result_q   <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            outValid_q <= 1'b0;
            bSel_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    outValid_q <= 1'b0;
                    bSel_q     <= 1'b0;
                    if (accept && !isM) begin
                        result_q   <= alu_res;
                        bSel_q     <= take;
                        outValid_q <= 1'b1;
                    end else if (accept && mOp[2] && (div_zero || div_ovf)) begin
                        result_q   <= special_res;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (accept) begin
                        mop_q    <= mOp;
                        neg_q    <= a_sgn ^ b_sgn;
                        rneg_q   <= a_sgn;
                        cnt_q    <= SW'(XLEN-1);
                        mplier_q <= b_mag;
                        if (mOp[2]) begin
                            acc_q   <= {{XLEN{1'b0}}, a_mag};
                            mcand_q <= {{XLEN{1'b0}}, b_mag};
                            state_q <= DIV;
                        end else begin
                            acc_q   <= '0;
                            mcand_q <= {{XLEN{1'b0}}, a_mag};
                            state_q <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q <= acc_next;
                    if (state_q == MUL) begin
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    if (cnt_q == '0) begin
                        result_q   <= m_res;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q - SW'(1);
                    end
                end
                DONE: begin
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    logic unused_m;
    assign unused_m = ^{isM, mOp};
    assign stall    = 1'b0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            outValid_q <= 1'b0;
            bSel_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            outValid_q <= accept;
            bSel_q     <= accept & take;
            if (accept) result_q <= alu_res;
        end
    end
`endif

    assign outValid = outValid_q;
    assign bSel     = bSel_q;
    assign result   = result_q;

endmodule

// File: tb/tb_ie_muldiv.sv
// Self-checking bench for ie_muldiv: random ALU/branch traffic against a plain-arithmetic model,
// plus RV32M scenarios when IE_MULDIV_M_EXT_EN is defined.

module tb_ie_muldiv;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rstN, inValid, flush, aluS1, aluS2, isM, doBranch, doJump;
    logic [31:0] r1, r2, imm, pcP, aluOutMem, wbData;
    logic [1:0]  fwdA, fwdB;
    logic [3:0]  aluOp;
    logic [2:0]  mOp, bCtrl;
    logic        stall, outValid, bSel;
    logic [31:0] result;
    logic [31:0] last_res;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ie_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .flush(flush),
        .r1(r1), .r2(r2), .imm(imm), .pcP(pcP), .aluOutMem(aluOutMem), .wbData(wbData),
        .fwdA(fwdA), .fwdB(fwdB), .aluS1(aluS1), .aluS2(aluS2), .aluOp(aluOp),
        .isM(isM), .mOp(mOp), .bCtrl(bCtrl), .doBranch(doBranch), .doJump(doJump),
        .stall(stall), .outValid(outValid), .result(result), .bSel(bSel)
    );

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return aluOutMem;
        if (sel == 2'b10) return wbData;
        return rf;
    endfunction

    function automatic logic [31:0] model_alu();
        logic [31:0] a, b;
        int sh;
        a  = aluS1 ? pick(fwdA, r1) : pcP;
        b  = aluS2 ? imm : pick(fwdB, r2);
        sh = b % 32;
        case (aluOp)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return $unsigned($signed(a) >>> sh);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_bsel();
        logic [31:0] a, b;
        logic c;
        a = pick(fwdA, r1);
        b = pick(fwdB, r2);
        case (bCtrl)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ($signed(a) < $signed(b));
            3'b101:  c = ($signed(a) >= $signed(b));
            3'b110:  c = (a < b);
            3'b111:  c = (a >= b);
            default: c = 1'b0;
        endcase
        return doJump | (doBranch & c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inValid = 0; flush = 0; aluS1 = 0; aluS2 = 0; isM = 0; doBranch = 0; doJump = 0;
        r1 = 0; r2 = 0; imm = 0; pcP = 0; aluOutMem = 0; wbData = 0;
        fwdA = 0; fwdB = 0; aluOp = 0; mOp = 0; bCtrl = 0;
    endtask

    task automatic rand_alu_inputs();
        r1 = $urandom;
        r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
        imm = $urandom; pcP = $urandom; aluOutMem = $urandom; wbData = $urandom;
        fwdA = 2'($urandom_range(0, 3)); fwdB = 2'($urandom_range(0, 3));
        aluS1 = 1'($urandom_range(0, 1)); aluS2 = 1'($urandom_range(0, 1));
        aluOp = 4'($urandom_range(0, 15)); bCtrl = 3'($urandom_range(0, 7));
        doBranch = 1'($urandom_range(0, 1)); doJump = ($urandom_range(0, 4) == 0);
        isM = 0; mOp = 3'($urandom_range(0, 7)); inValid = 1; flush = 0;
    endtask

    task automatic test_reset();
        rstN = 1;
        clear_inputs();
        #2 rstN = 0;
        #1;
        if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", outValid); end
        checks++;
        if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
        checks++;
        if (bSel !== 1'b0) begin failures++; $display("FAIL reset_bsel: got %b want 0", bSel); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++;
        r1 = 1; imm = 1; aluS1 = 1; aluS2 = 1; inValid = 1;
        tick();
        if (outValid !== 1'b0) begin failures++; $display("FAIL reset_hold_valid: got %b want 0", outValid); end
        checks++;
        clear_inputs();
        rstN = 1;
        tick();
        last_res = 32'd0;
    endtask

    task automatic test_directed();
        clear_inputs();
        aluOp = 4'd0; r1 = 5; imm = 7; aluS1 = 1; aluS2 = 1; inValid = 1;
        tick();
        if (outValid !== 1'b1) begin failures++; $display("FAIL add_valid: got %b want 1", outValid); end
        checks++;
        if (result !== 32'd12) begin failures++; $display("FAIL add_result: got %h want 0000000c", result); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL add_stall: got %b want 0", stall); end
        checks++;
        clear_inputs();
        fwdA = 2'b01; aluOutMem = 32'h10; r1 = 0; aluOp = 4'd1; r2 = 1; aluS1 = 1; inValid = 1;
        tick();
        if (result !== 32'h0F) begin failures++; $display("FAIL fwd_mem: got %h want 0000000f", result); end
        checks++;
        fwdA = 2'b10; wbData = 32'h20;
        tick();
        if (result !== 32'h1F) begin failures++; $display("FAIL fwd_wb: got %h want 0000001f", result); end
        checks++;
        clear_inputs();
        r1 = 3; r2 = 3; bCtrl = 3'b000; doBranch = 1; inValid = 1;
        tick();
        if (bSel !== 1'b1) begin failures++; $display("FAIL beq_taken: got %b want 1", bSel); end
        checks++;
        r2 = 4;
        tick();
        if (bSel !== 1'b0) begin failures++; $display("FAIL beq_not_taken: got %b want 0", bSel); end
        checks++;
        doBranch = 0; doJump = 1; bCtrl = 3'($urandom_range(0, 7)); r2 = $urandom;
        tick();
        if (bSel !== 1'b1) begin failures++; $display("FAIL jump: got %b want 1", bSel); end
        checks++;
        last_res = 32'd0;
        inValid = 0;
        tick();
    endtask

    task automatic test_alu_random();
        logic [31:0] exp_r;
        logic exp_b;
        for (int i = 0; i < 80; i++) begin
            rand_alu_inputs();
            exp_r = model_alu();
            exp_b = model_bsel();
            tick();
            if (outValid !== 1'b1) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want 1", i, outValid); end
            checks++;
            if (result !== exp_r) begin failures++; $display("FAIL rnd_result[%0d] op=%0d: got %h want %h", i, aluOp, result, exp_r); end
            checks++;
            if (bSel !== exp_b) begin failures++; $display("FAIL rnd_bsel[%0d] bctrl=%0d: got %b want %b", i, bCtrl, bSel, exp_b); end
            checks++;
            if (stall !== 1'b0) begin failures++; $display("FAIL rnd_stall[%0d]: got %b want 0", i, stall); end
            checks++;
            last_res = exp_r;
        end
        inValid = 0;
        tick();
        if (outValid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b want 0", outValid); end
        checks++;
        if (result !== last_res) begin failures++; $display("FAIL idle_hold: got %h want %h", result, last_res); end
        checks++;
    endtask

    task automatic test_flush();
        rand_alu_inputs();
        flush = 1;
        tick();
        if (outValid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", outValid); end
        checks++;
        if (result !== last_res) begin failures++; $display("FAIL flush_hold: got %h want %h", result, last_res); end
        checks++;
        clear_inputs();
    endtask

`ifdef IE_MULDIV_M_EXT_EN
    function automatic logic [31:0] model_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 1;
    endfunction

    task automatic do_m_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res, output int stall_bad,
                           output logic done_stall, output logic done_bsel);
        clear_inputs();
        isM = 1; mOp = op; r1 = a; r2 = b; aluS1 = 1; inValid = 1;
        tick();
        inValid = 0;
        lat = 1;
        stall_bad = 0;
        while (outValid !== 1'b1 && lat < 100) begin
            if (stall !== 1'b1) stall_bad++;
            tick();
            lat++;
        end
        res = result;
        done_stall = stall;
        done_bsel = bSel;
    endtask

    task automatic test_m_random();
        logic [31:0] a, b, res;
        logic [2:0] op;
        logic ds, db;
        int lat, sb;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: a = 32'h8000_0000; 1: a = 32'hFFFF_FFFF; 2: a = 32'd0; default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0; 1: b = 32'hFFFF_FFFF; 2: b = 32'd7; default: b = $urandom;
            endcase
            do_m_op(op, a, b, lat, res, sb, ds, db);
            if (lat != model_lat(op, a, b)) begin failures++; $display("FAIL m_lat[%0d] op=%0d: got %0d want %0d", i, op, lat, model_lat(op, a, b)); end
            checks++;
            if (res !== model_m(op, a, b)) begin failures++; $display("FAIL m_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, model_m(op, a, b)); end
            checks++;
            if (sb != 0 || ds !== 1'b1) begin failures++; $display("FAIL m_stall[%0d]: low %0d cycles, done stall %b want 1", i, sb, ds); end
            checks++;
            if (db !== 1'b0) begin failures++; $display("FAIL m_bsel[%0d]: got %b want 0", i, db); end
            checks++;
            tick();
            if (outValid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL m_release[%0d]: valid %b stall %b want 0 0", i, outValid, stall); end
            checks++;
        end
    endtask

    task automatic test_m_directed();
        logic [31:0] res;
        logic ds, db;
        int lat, sb;
        do_m_op(3'b001, 32'hFFFF_FFFF, 32'h2, lat, res, sb, ds, db);
        if (lat != 33 || res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulh: lat %0d res %h want 33 ffffffff", lat, res); end
        checks++;
        tick();
        do_m_op(3'b100, 32'd7, 32'd0, lat, res, sb, ds, db);
        if (lat != 1 || res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_zero: lat %0d res %h want 1 ffffffff", lat, res); end
        checks++;
        tick();
        do_m_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sb, ds, db);
        if (res !== 32'd0) begin failures++; $display("FAIL rem_ovf: got %h want 0", res); end
        checks++;
        tick();
    endtask

    task automatic test_m_flush();
        int seen = 0;
        clear_inputs();
        isM = 1; mOp = 3'b101; r1 = 100; r2 = 7; aluS1 = 1; inValid = 1;
        tick();
        inValid = 0;
        repeat (9) tick();
        flush = 1;
        tick();
        flush = 0;
        if (stall !== 1'b0 || outValid !== 1'b0) begin failures++; $display("FAIL flush_m: stall %b valid %b want 0 0", stall, outValid); end
        checks++;
        repeat (40) begin tick(); if (outValid === 1'b1) seen++; end
        if (seen != 0) begin failures++; $display("FAIL flush_m_ghost: got %0d valid cycles want 0", seen); end
        checks++;
        clear_inputs();
        r1 = 9; imm = 4; aluS1 = 1; aluS2 = 1; inValid = 1;
        tick();
        inValid = 0;
        if (outValid !== 1'b1 || result !== 32'd13) begin failures++; $display("FAIL flush_next_add: valid %b res %h want 1 0000000d", outValid, result); end
        checks++;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        clear_inputs();
        isM = 1; mOp = 3'b000; r1 = 32'd1234; r2 = 32'd5678; aluS1 = 1; inValid = 1;
        tick();
        inValid = 0;
        repeat (5) tick();
        rstN = 0;
        #1;
        if (stall !== 1'b0 || outValid !== 1'b0 || bSel !== 1'b0 || result !== 32'd0) begin
            failures++; $display("FAIL reset_mid: stall %b valid %b bsel %b res %h want all 0", stall, outValid, bSel, result);
        end
        checks++;
        #2 rstN = 1;
        repeat (40) begin tick(); if (outValid === 1'b1 || stall === 1'b1) seen++; end
        if (seen != 0) begin failures++; $display("FAIL reset_mid_ghost: got %0d active cycles want 0", seen); end
        checks++;
    endtask
`else
    task automatic test_m_ignored();
        logic [31:0] exp_r;
        for (int i = 0; i < 20; i++) begin
            rand_alu_inputs();
            isM = 1;
            exp_r = model_alu();
            tick();
            if (outValid !== 1'b1 || result !== exp_r) begin failures++; $display("FAIL m_ignored[%0d]: valid %b res %h want 1 %h", i, outValid, result, exp_r); end
            checks++;
            if (stall !== 1'b0) begin failures++; $display("FAIL m_ignored_stall[%0d]: got %b want 0", i, stall); end
            checks++;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        r1 = 32'h55; imm = 32'h1; aluS1 = 1; aluS2 = 1; doJump = 1; inValid = 1;
        tick();
        rstN = 0;
        #1;
        if (outValid !== 1'b0 || bSel !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
            failures++; $display("FAIL reset_mid: stall %b valid %b bsel %b res %h want all 0", stall, outValid, bSel, result);
        end
        checks++;
        clear_inputs();
        #2 rstN = 1;
        tick();
        if (outValid !== 1'b0) begin failures++; $display("FAIL reset_mid_ghost: got %b want 0", outValid); end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_alu_random();
        test_flush();
`ifdef IE_MULDIV_M_EXT_EN
        test_m_directed();
        test_m_random();
        test_m_flush();
`else
        test_m_ignored();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
